sr_reg_bank: RTL

- Parametrised successor to the single-bit SR flip-flop: a bank of WIDTH independent clocked SR storage cells sharing one clock, one reset and one enable.
- Adds a selectable S=R=1 resolution mode, a programmable reset value and a per-channel sticky conflict flag.
- Used wherever a group of set/clear status bits is needed, such as interrupt-pending, error-latch or handshake-done vectors.

---
 rtl/sr_reg_bank.sv | 86 ++++++++
 1 files changed

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH clocked SR cells with selectable S=R=1 resolution and sticky conflict flags.
// Optional saturating conflict-cycle counter compiled in with SR_REG_BANK_CONFLICT_CNT_EN.
module sr_reg_bank #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      MODE    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int unsigned      CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             conflict_clr,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QB,
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
   output logic [CNT_W-1:0] conflict_cnt,
`endif
   output logic [WIDTH-1:0] conflict
);

   if (WIDTH < 1) begin : g_bad_width
      $error("sr_reg_bank: WIDTH must be at least 1");
   end
   if (MODE > 3) begin : g_bad_mode
      $error("sr_reg_bank: MODE must be 0..3");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("sr_reg_bank: CNT_W must be at least 1");
   end

   logic [WIDTH-1:0] both;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] both_val;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] conflict_next;

   // Non-conflicting channels follow plain set/clear; conflicting ones take the MODE resolution.
   always_comb begin
      both     = S & R;
      base     = (Q | S) & ~R;
      both_val = Q;
      case (MODE)
         1:       both_val = '1;
         2:       both_val = '0;
         3:       both_val = ~Q;
         default: both_val = Q;
      endcase
      q_next        = (base & ~both) | (both_val & both);
      conflict_next = (conflict & ~{WIDTH{conflict_clr}}) | (both & {WIDTH{en}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Q        <= RST_VAL;
         conflict <= '0;
      end else begin
         if (en) begin
            Q <= q_next;
         end
         conflict <= conflict_next;
      end
   end

   assign QB = ~Q;

`ifdef SR_REG_BANK_CONFLICT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic hit;
   assign hit = en & (|both);

   // Counts conflict cycles, not conflicting channels; a clear that meets a new conflict lands on 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (conflict_clr) begin
         conflict_cnt <= CNT_W'(hit);
      end else if (hit && (conflict_cnt != CNT_MAX)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
